// File: rtl/immgen_pipe_if.sv
// Bus bundle for the immediate generator: producer-side payload handshake,
// consumer-side result handshake, and the synchronous flush strobe.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its payload stable until the
// transfer; ready may change freely and never depends combinationally on
// valid of the same interface.
interface immgen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_sel;
   logic [24:0]       in_inst;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_imm;
   logic [TAG_W-1:0]  out_tag;
   logic              out_illegal;

   // Drives payload and consumer ready (decode front / bench side).
   modport master (
      output flush, in_valid, in_sel, in_inst, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal
   );

   // The immediate generator itself.
   modport slave (
      input  flush, in_valid, in_sel, in_inst, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal
   );
endinterface

// File: rtl/immgen_pipe.sv
// Registered immediate generator: decodes the immediate at push time and
// queues it in a 2-entry elastic buffer so in_ready comes from flops only.
module immgen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   immgen_pipe_if.slave  bus
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("immgen_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   localparam logic [2:0] SEL_I  = 3'd0;
   localparam logic [2:0] SEL_S  = 3'd1;
   localparam logic [2:0] SEL_B  = 3'd2;
   localparam logic [2:0] SEL_U  = 3'd3;
   localparam logic [2:0] SEL_J  = 3'd4;
   localparam logic [2:0] SEL_Z  = 3'd5;
   localparam logic [2:0] SEL_SH = 3'd6;

   // Port bit k holds instruction bit k+7.
   logic [24:0] p;
   assign p = bus.in_inst;

   // Raw fields as signed values so a width cast sign-extends them.
   logic signed [11:0] i_val;
   logic signed [11:0] s_val;
   logic signed [12:0] b_val;
   logic signed [31:0] u_val;
   logic signed [20:0] j_val;

   assign i_val = p[24:13];
   assign s_val = {p[24:18], p[4:0]};
   assign b_val = {p[24], p[0], p[23:18], p[4:1], 1'b0};
   assign u_val = {p[24:5], 12'b0};
   assign j_val = {p[24], p[12:5], p[13], p[23:14], 1'b0};

   logic [XLEN-1:0] new_imm;
   logic            new_illegal;

   // Format decode of the incoming payload.
   always_comb begin
      new_imm     = '0;
      new_illegal = 1'b0;
      case (bus.in_sel)
         SEL_I:  new_imm = XLEN'(i_val);
         SEL_S:  new_imm = XLEN'(s_val);
         SEL_B:  new_imm = XLEN'(b_val);
         SEL_U:  new_imm = XLEN'(u_val);
         SEL_J:  new_imm = XLEN'(j_val);
         SEL_Z:  new_imm = XLEN'(p[12:8]);
         SEL_SH: begin
            if (XLEN == 64) begin
               new_imm = XLEN'(p[18:13]);
            end else begin
               new_imm     = XLEN'(p[17:13]);
               new_illegal = p[18];
            end
         end
         default: begin
            new_imm     = '0;
            new_illegal = 1'b1;
         end
      endcase
   end

   logic [XLEN-1:0]  mem_imm [2];
   logic [TAG_W-1:0] mem_tag [2];
   logic             mem_ill [2];
   logic             head;
   logic             tail;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign bus.in_ready    = (count != 2'd2);
   assign bus.out_valid   = (count != 2'd0);
   assign push            = bus.in_valid & bus.in_ready;
   assign pop             = bus.out_valid & bus.out_ready;
   assign bus.out_imm     = mem_imm[head];
   assign bus.out_tag     = mem_tag[head];
   assign bus.out_illegal = mem_ill[head];

   // FIFO pointers, occupancy and storage; flush empties without clearing data.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem_imm[i] <= '0;
            mem_tag[i] <= '0;
            mem_ill[i] <= 1'b0;
         end
      end else if (bus.flush) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem_imm[tail] <= new_imm;
            mem_tag[tail] <= bus.in_tag;
            mem_ill[tail] <= new_illegal;
            tail          <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Accepts a 25-bit instruction payload (inst[31:7]) with a format select and a sideband tag over a valid/ready handshake.
- Produces an XLEN-wide immediate through a 2-entry elastic buffer, so decode can stall without a combinational ready path.
- Adds RV64 sign extension, CSR zimm and shift-amount formats, plus an illegal flag.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64
TAG_W, 8, width of pass-through sideband tag (e.g. rd/ROB index)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
flush  input  1  synchronous buffer clear
in_valid  input  1  input payload valid
in_ready  output  1  block can accept payload this cycle
in_sel  input  3  format: 0=I 1=S 2=B 3=U 4=J 5=Z(zimm) 6=SH(shamt) 7=reserved
in_inst  input  25  instruction bits [31:7]; bit 0 of port = inst[7]
in_tag  input  TAG_W  sideband, returned unchanged
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_imm  output  XLEN  generated immediate
out_tag  output  TAG_W  tag of head entry
out_illegal  output  1  head entry had reserved sel or out-of-range shamt

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high; it dominates flush, push and pop.
- Storage is a 2-entry FIFO (head/tail pointers, 2-bit count 0..2).
- Immediate is computed combinationally from in_* at push time and stored, not recomputed at output.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != 2), derived from registered count only. It has no dependence on out_ready.
- out_valid = (count != 0). out_imm/out_tag/out_illegal = head entry; they hold stable while out_valid & !out_ready.
- Latency: payload pushed at edge N appears on out_* after edge N when the FIFO was empty. No bypass path.
- Push and pop in the same cycle with count=1: count stays 1, head advances, new entry written.
- With count=2, push is impossible (in_ready=0); a pop drops count to 1, and in_ready=1 the following cycle.
- Pointers wrap modulo 2.
- Reset: count=0, pointers=0, out_valid=0, storage cleared so out_imm=0, out_tag=0, out_illegal=0. in_ready=1 from the first cycle after rst deasserts. A push presented while rst=1 is discarded.
- Reset mid-operation discards all entries.
- flush=1 (rst=0): count=0 and pointers=0 at the edge. A push in the same cycle is discarded. out_* data is not cleared, but out_valid=0.
- Formats (s = inst[31], all sign extension to XLEN):
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25],inst[11:7]}).
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - U: sext({inst[31:12],12'b0}). Upper 32 bits replicate s when XLEN=64.
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - Z: zero-extended inst[19:15].
  - SH: XLEN=64 gives zero-extended inst[25:20]. XLEN=32 gives zero-extended inst[24:20]; illegal=1 if inst[25]=1.
  - sel=7: imm=0, illegal=1.
- illegal=0 for all other cases.
- XLEN values other than 32/64: elaboration error.

Test Plan:
- XLEN=32, sel=I, inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, illegal=0.
- sel=B with inst=0xFE000EE3 -> 0xFFFFFFFC. sel=J with inst=0x001000EF -> 0x00000800. sel=Z with inst[19:15]=31 -> 0x0000001F.
- XLEN=64, sel=U, inst=0x80000037 -> out_imm=0xFFFFFFFF80000000. sel=U with inst=0x123450B7 -> 0x0000000012345000.
- XLEN=32, sel=SH, inst[25:20]=0x21 -> out_imm=0x00000001, illegal=1. sel=7 -> imm=0, illegal=1.
- Backpressure: out_ready=0, push tags 1,2,3 back-to-back -> 1 and 2 accepted, in_ready=0 on third. Raise out_ready -> outputs tags 1,2,3 in order. out_imm is stable while stalled.
- Flush with count=2 plus a simultaneous push -> next cycle out_valid=0, in_ready=1, and the pushed tag never appears.
- rst asserted with count=2 -> next cycle out_valid=0, out_imm=0, out_tag=0.
